result_collector: RTL and testbench
===================================

// Module: result_collector
// PURPOSE
//   Downstream stage of the MAC output buffer. Captures each 19-bit signed result word
//   presented with a one-cycle write strobe and stores it in an N x N result memory.
//   Stores results in row-major order. Flags completion of a full matrix.
//   Provides a registered readback port for the host/testbench to drain results.
// PARAMETERS
//   N       8   matrix dimension; N*N results per matrix
//   DATA_W  19  result word width (signed), matches MAC product width
//   ADDR_W  6   memory address width; must satisfy 2**ADDR_W >= N*N
// PORTS
//   clk         in   1       single clock, all logic on posedge
//   reset       in   1       synchronous, active-high
//   start       in   1       pulse: clear counters/flags, begin collecting a new matrix
//   out         in   DATA_W  signed result word from buffer stage
//   writeToReg  in   1       strobe: out is valid this cycle
//   rd_en       in   1       read request
//   rd_addr     in   ADDR_W  read address (row*N + col)
//   rd_data     out  DATA_W  read data, registered
//   rd_valid    out  1       high exactly one cycle after an accepted rd_en
//   wr_row      out  ADDR_W  row index of the next write
//   wr_col      out  ADDR_W  column index of the next write
//   busy        out  1       high in COLLECT
//   done        out  1       high in DONE; held until start or reset
//   overflow    out  1       sticky: strobe received in DONE
// BEHAVIOUR
//   - Reset (sync, high): state=IDLE; wr_row=wr_col=0; rd_data=0; rd_valid=0; busy=0;
//     done=0; overflow=0. Memory contents are not cleared; they are undefined until written.
//   - FSM states:
//     - IDLE    -start-> COLLECT
//     - COLLECT -(N*N-th strobe accepted)-> DONE
//     - COLLECT -start-> COLLECT (restart)
//     - DONE    -start-> COLLECT
//   - start, any state: next cycle wr_row=wr_col=0, done=0, overflow=0, state=COLLECT.
//   - start has priority: a strobe in the same cycle as start is dropped.
//   - COLLECT + writeToReg: mem[wr_row*N+wr_col] <= out, stored as-is (no truncation).
//     - wr_col increments. At wr_col=N-1, wr_col wraps to 0 and wr_row increments.
//     - On the strobe at (N-1,N-1): state=DONE next cycle, counters wrap to (0,0), done=1.
//   - Strobe in IDLE: ignored; no memory write; no flag set.
//   - Strobe in DONE: memory unchanged; overflow=1 (sticky until start or reset).
//   - Strobes may arrive back-to-back every cycle; every strobe in COLLECT is accepted.
//   - Read: rd_en at cycle t gives rd_data=mem[rd_addr] and rd_valid=1 at t+1.
//     - Without rd_en, rd_valid=0 and rd_data holds its last value.
//     - Reads are allowed in any state.
//     - rd_addr >= N*N returns 0.
//   - Read and write to the same address in the same cycle: rd_data returns the OLD
//     contents (read-before-write).
//   - Reset asserted mid-COLLECT: abort; outputs take reset values next cycle;
//     partial data is not guaranteed.
// STRUCTURE
//   - Shared package/include matmul_defs: DATA_W, N, ADDR_W, FSM state encodings
//     (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2). Reused by the MAC and buffer stages.
//   - Sub-module result_ram: simple dual-port, 1 write port, 1 registered read port,
//     read-before-write, no reset on the array.
//   - Top level holds the FSM, row/col counters, flags, and the address multiply/concat.
// TESTING
//   1. Reset, then start. Strobe 64 back-to-back values -100..-37 (N=8).
//      -> done=1 the cycle after the 64th strobe; busy=0.
//      -> reading addr 0..63 returns -100..-37; rd_valid is 1 cycle after each rd_en.
//   2. Strobe every 4th cycle with out=0x3FFFF and 0x40000 alternating.
//      -> wr_col/wr_row step 0..7 with wrap; the stored signed extremes read back exactly.
//   3. After done, strobe out=5.
//      -> overflow=1; addr 0 unchanged.
//      Then start -> overflow=0, done=0, counters (0,0).
//   4. start and writeToReg in the same cycle with out=42.
//      -> no write; the next strobe (out=7) lands at addr 0.
//   5. Assert reset after 20 strobes -> all outputs at reset values next cycle, state IDLE.
//      Then strobe with no start -> ignored; wr_col stays 0.
//   6. rd_en with rd_addr=3 in the same cycle as the write to addr 3 (old=11, new=99).
//      -> rd_data=11. A following read returns 99.

Source files
------------

// File: rtl/result_collector_pkg.sv
// rtl/result_collector_pkg.sv - shared sizes, FSM encoding and address helper for the result collector
package result_collector_pkg;

    localparam int N      = 8;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = N * N;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic [ADDR_W-1:0]        addr_t;
    typedef logic signed [DATA_W-1:0] data_t;

    // Row-major flat address of (row, col).
    function automatic addr_t calc_addr(input addr_t row, input addr_t col);
        return addr_t'(int'(row) * N + int'(col));
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// rtl/result_collector_if.sv - write strobe, readback and status signals of the result collector
interface result_collector_if;
    import result_collector_pkg::*;

    logic  start;
    data_t out;
    logic  writeToReg;
    logic  rd_en;
    addr_t rd_addr;
    data_t rd_data;
    logic  rd_valid;
    addr_t wr_row;
    addr_t wr_col;
    logic  busy;
    logic  done;
    logic  overflow;

    modport master (
        output start, out, writeToReg, rd_en, rd_addr,
        input  rd_data, rd_valid, wr_row, wr_col, busy, done, overflow
    );

    modport slave (
        input  start, out, writeToReg, rd_en, rd_addr,
        output rd_data, rd_valid, wr_row, wr_col, busy, done, overflow
    );

endinterface

// File: rtl/result_collector_ram.sv
// rtl/result_collector_ram.sv - simple dual-port result memory, registered read-before-write port
module result_ram
    import result_collector_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  data_t wr_data,
    input  logic  rd_en,
    input  addr_t rd_addr,
    output data_t rd_data
);

    data_t mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking update of mem gives read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - collects an N x N matrix of result words in row-major order
module result_collector
    import result_collector_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    result_collector_if.slave bus
);

    state_t state, state_nxt;
    addr_t  row, row_nxt;
    addr_t  col, col_nxt;
    logic   overflow, overflow_nxt;
    logic   wr_en;
    logic   rd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            overflow <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        row_nxt      = row;
        col_nxt      = col;
        overflow_nxt = overflow;
        wr_en        = 1'b0;

        // start wins over any strobe arriving in the same cycle.
        if (bus.start) begin
            state_nxt    = COLLECT;
            row_nxt      = '0;
            col_nxt      = '0;
            overflow_nxt = 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.writeToReg) begin
                        wr_en = 1'b1;
                        if (col == addr_t'(N - 1)) begin
                            col_nxt = '0;
                            if (row == addr_t'(N - 1)) begin
                                row_nxt   = '0;
                                state_nxt = DONE;
                            end else begin
                                row_nxt = row + 1'b1;
                            end
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.writeToReg) begin
                        overflow_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
        end
    end

    result_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en && !reset),
        .wr_addr (calc_addr(row, col)),
        .wr_data (bus.out),
        .rd_en   (bus.rd_en),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

    assign bus.rd_valid = rd_valid;
    assign bus.wr_row   = row;
    assign bus.wr_col   = col;
    assign bus.busy     = (state == COLLECT);
    assign bus.done     = (state == DONE);
    assign bus.overflow = overflow;

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - directed vector bench for result_collector
module tb_result_collector;
    import result_collector_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    result_collector_if bus();

    result_collector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic start;
        logic wr;
        int   out;
        logic rd_en;
        int   rd_addr;
        logic e_valid;
        int   e_data;
        int   e_row;
        int   e_col;
        logic e_busy;
        logic e_done;
        logic e_ovf;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic s, input logic w, input int o, input logic r,
                                input int ra, input logic ev, input int ed, input int er,
                                input int ec, input logic eb, input logic edn, input logic eo);
        vec_t v;
        v.start = s;  v.wr = w;  v.out = o;  v.rd_en = r;  v.rd_addr = ra;
        v.e_valid = ev; v.e_data = ed; v.e_row = er; v.e_col = ec;
        v.e_busy = eb; v.e_done = edn; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input int er, input int ec,
                              input logic eb, input logic edn, input logic eo);
        chk({tag, " wr_row"},   int'(bus.wr_row),   er);
        chk({tag, " wr_col"},   int'(bus.wr_col),   ec);
        chk({tag, " busy"},     int'(bus.busy),     int'(eb));
        chk({tag, " done"},     int'(bus.done),     int'(edn));
        chk({tag, " overflow"}, int'(bus.overflow), int'(eo));
    endtask

    task automatic strobe(input int val);
        bus.writeToReg = 1'b1;
        bus.out = DATA_W'(val);
        tick();
        bus.writeToReg = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        int exp;

        bus.start = 1'b0; bus.out = '0; bus.writeToReg = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;

        // Test 3, 4 and 6 cycle vectors: inputs for one cycle, outputs expected after it.
        tbl[0]  = mk(0, 1,  5, 1, 0, 1, 262143, 0, 0, 0, 1, 1);
        tbl[1]  = mk(1, 0,  0, 0, 0, 0, 262143, 0, 0, 1, 0, 0);
        tbl[2]  = mk(1, 1, 42, 0, 0, 0, 262143, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1,  7, 0, 0, 0, 262143, 0, 1, 1, 0, 0);
        tbl[4]  = mk(0, 0,  0, 1, 0, 1,      7, 0, 1, 1, 0, 0);
        tbl[5]  = mk(0, 1,  1, 0, 0, 0,      7, 0, 2, 1, 0, 0);
        tbl[6]  = mk(0, 1,  2, 0, 0, 0,      7, 0, 3, 1, 0, 0);
        tbl[7]  = mk(0, 1, 11, 0, 0, 0,      7, 0, 4, 1, 0, 0);
        tbl[8]  = mk(1, 0,  0, 0, 0, 0,      7, 0, 0, 1, 0, 0);
        tbl[9]  = mk(0, 1, 20, 0, 0, 0,      7, 0, 1, 1, 0, 0);
        tbl[10] = mk(0, 1, 21, 0, 0, 0,      7, 0, 2, 1, 0, 0);
        tbl[11] = mk(0, 1, 22, 0, 0, 0,      7, 0, 3, 1, 0, 0);
        tbl[12] = mk(0, 1, 99, 1, 3, 1,     11, 0, 4, 1, 0, 0);
        tbl[13] = mk(0, 0,  0, 1, 3, 1,     99, 0, 4, 1, 0, 0);
        tbl[14] = mk(0, 0,  0, 1, 0, 1,     20, 0, 4, 1, 0, 0);
        tbl[15] = mk(0, 0,  0, 0, 0, 0,     20, 0, 4, 1, 0, 0);

        repeat (2) tick();
        reset = 1'b0;
        chk("reset rd_data", int'(bus.rd_data), 0);
        chk("reset rd_valid", int'(bus.rd_valid), 0);
        chk_status("reset", 0, 0, 0, 0, 0);

        // Test 1: full matrix back-to-back
        do_start();
        chk_status("t1 start", 0, 0, 1, 0, 0);
        bus.writeToReg = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.out = DATA_W'(-100 + i);
            tick();
            chk("t1 wr_col", int'(bus.wr_col), (i + 1) % 8);
            chk("t1 done", int'(bus.done), (i == 63) ? 1 : 0);
        end
        bus.writeToReg = 1'b0;
        chk_status("t1 end", 0, 0, 0, 1, 0);
        for (int a = 0; a < 64; a++) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = ADDR_W'(a);
            tick();
            chk("t1 rd_valid", int'(bus.rd_valid), 1);
            chk("t1 rd_data", int'(bus.rd_data), -100 + a);
        end
        bus.rd_en = 1'b0;
        tick();
        chk("t1 rd_valid idle", int'(bus.rd_valid), 0);
        chk("t1 rd_data hold", int'(bus.rd_data), -37);

        // Test 2: sparse strobes with signed extremes
        do_start();
        for (int i = 0; i < 64; i++) begin
            chk("t2 wr_row", int'(bus.wr_row), i / 8);
            chk("t2 wr_col", int'(bus.wr_col), i % 8);
            strobe((i % 2 == 0) ? 32'h3FFFF : 32'h40000);
            if (i < 63) chk("t2 done early", int'(bus.done), 0);
            repeat (3) tick();
        end
        chk_status("t2 end", 0, 0, 0, 1, 0);
        for (int a = 0; a < 64; a++) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = ADDR_W'(a);
            tick();
            exp = (a % 2 == 0) ? 262143 : -262144;
            chk("t2 rd_data", int'(bus.rd_data), exp);
        end
        bus.rd_en = 1'b0;
        tick();

        // Tests 3, 4, 6 from the vector table
        for (int k = 0; k < 16; k++) begin
            bus.start = tbl[k].start;
            bus.writeToReg = tbl[k].wr;
            bus.out = DATA_W'(tbl[k].out);
            bus.rd_en = tbl[k].rd_en;
            bus.rd_addr = ADDR_W'(tbl[k].rd_addr);
            tick();
            chk($sformatf("vec%0d rd_valid", k), int'(bus.rd_valid), int'(tbl[k].e_valid));
            chk($sformatf("vec%0d rd_data", k), int'(bus.rd_data), tbl[k].e_data);
            chk_status($sformatf("vec%0d", k), tbl[k].e_row, tbl[k].e_col,
                       tbl[k].e_busy, tbl[k].e_done, tbl[k].e_ovf);
        end
        bus.start = 1'b0; bus.writeToReg = 1'b0; bus.rd_en = 1'b0;

        // Test 5: reset mid-collect, then strobe without start
        do_start();
        for (int i = 0; i < 20; i++) strobe(i);
        chk_status("t5 pre", 2, 4, 1, 0, 0);
        reset = 1'b1;
        bus.writeToReg = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        reset = 1'b0;
        bus.writeToReg = 1'b0;
        bus.rd_en = 1'b0;
        chk("t5 rd_data", int'(bus.rd_data), 0);
        chk("t5 rd_valid", int'(bus.rd_valid), 0);
        chk_status("t5 reset", 0, 0, 0, 0, 0);
        strobe(123);
        chk_status("t5 idle strobe", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
